// File: rtl/best_match_pkg.sv
// Shared types, constants and fp32 helpers for the best-match tracker.
`timescale 1ns/1ps
package best_match_pkg;

   typedef enum logic [1:0] {
      ACCUM      = 2'd0,
      EMIT_IDX   = 2'd1,
      EMIT_SCORE = 2'd2
   } state_e;

   localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;

   // Record word 0 layout: {found, zero pad, idx}
   localparam int REC_FOUND_BIT = 31;
   localparam int REC_IDX_LSB   = 0;

   // NaN: all-ones exponent with a non-zero mantissa (infinities are not NaN)
   function automatic logic fp32_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Maps fp32 onto an unsigned key whose integer order matches numeric order,
   // with -0.0 landing just below +0.0
   function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
      return x[31] ? ~x : (x ^ 32'h80000000);
   endfunction

   // Inverse of fp32_order_key, so only the key needs to be stored
   function automatic logic [31:0] fp32_from_key(input logic [31:0] k);
      return k[31] ? (k ^ 32'h80000000) : ~k;
   endfunction

endpackage

// File: rtl/fp32_max_select.sv
// Combinational compare of one candidate score against the running best key.
`timescale 1ns/1ps
module fp32_max_select
   import best_match_pkg::*;
(
   input  logic [31:0] candidate,
   input  logic [31:0] best_key,
   input  logic        found,
   output logic        update,
   output logic [31:0] cand_key
);

   // Strict greater-than keeps the earliest index on ties; NaN never wins
   always_comb begin
      cand_key = fp32_order_key(candidate);
      update   = !fp32_is_nan(candidate) && (!found || (cand_key > best_key));
   end

endmodule

// File: rtl/best_match_tracker.sv
// Tracks the max fp32 score and its index over a sweep, then emits a 2-word record.
`timescale 1ns/1ps
module best_match_tracker
   import best_match_pkg::*;
#(
   parameter int NUM_ENTRIES = 128,
   parameter int IDX_W       = 16
)(
   input  logic        bus_clk,
   input  logic        rst_n,
   input  logic        score_tvalid,
   output logic        score_tready,
   input  logic [31:0] score_tdata,
   input  logic        score_tlast,
   input  logic        fifo_full,
   output logic        fifo_wren,
   output logic [31:0] fifo_din,
   output logic        sweep_done,
   output logic [15:0] sweep_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e             state_q, state_d;
   logic [31:0]        best_key_q, best_key_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic               found_q, found_d;
   logic [IDX_W-1:0]   entry_cnt_q, entry_cnt_d;
   logic [15:0]        sweep_count_q, sweep_count_d;

   logic               accept;
   logic               sweep_end;
   logic               upd;
   logic [31:0]        cand_key;

   fp32_max_select u_sel (
      .candidate (score_tdata),
      .best_key  (best_key_q),
      .found     (found_q),
      .update    (upd),
      .cand_key  (cand_key)
   );

   assign accept    = score_tvalid && score_tready;
   assign sweep_end = score_tlast || (entry_cnt_q == LAST_IDX);

   // Outputs: handshakes and the record word muxed from the registered fields
   always_comb begin
      score_tready = rst_n && (state_q == ACCUM);
      fifo_wren    = ((state_q == EMIT_IDX) || (state_q == EMIT_SCORE)) && !fifo_full;
      sweep_done   = (state_q == EMIT_SCORE) && fifo_wren;
      sweep_count  = sweep_count_q;
      fifo_din     = 32'd0;
      if (state_q == EMIT_IDX) begin
         fifo_din[REC_IDX_LSB +: IDX_W] = best_idx_q;
         fifo_din[REC_FOUND_BIT]        = found_q;
      end else if (state_q == EMIT_SCORE) begin
         fifo_din = found_q ? fp32_from_key(best_key_q) : FP32_NEG_INF;
      end
   end

   // Next state: emit states only move on an actual FIFO write
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:      if (accept && sweep_end) state_d = EMIT_IDX;
         EMIT_IDX:   if (fifo_wren)           state_d = EMIT_SCORE;
         EMIT_SCORE: if (fifo_wren)           state_d = ACCUM;
         default:                             state_d = ACCUM;
      endcase
   end

   // Datapath: running best, entry counter and sweep counter
   always_comb begin
      best_key_d    = best_key_q;
      best_idx_d    = best_idx_q;
      found_d       = found_q;
      entry_cnt_d   = entry_cnt_q;
      sweep_count_d = sweep_count_q;
      if (state_q == ACCUM && accept) begin
         if (upd) begin
            best_key_d = cand_key;
            best_idx_d = entry_cnt_q;
            found_d    = 1'b1;
         end
         // Hold the counter on the closing score so it never passes NUM_ENTRIES-1
         if (!sweep_end) entry_cnt_d = entry_cnt_q + IDX_W'(1);
      end
      if (state_q == EMIT_SCORE && fifo_wren) begin
         best_key_d    = 32'd0;
         best_idx_d    = '0;
         found_d       = 1'b0;
         entry_cnt_d   = '0;
         sweep_count_d = sweep_count_q + 16'd1;
      end
   end

   // State register
   always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // Record and counter registers
   always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) begin
         best_key_q    <= 32'd0;
         best_idx_q    <= '0;
         found_q       <= 1'b0;
         entry_cnt_q   <= '0;
         sweep_count_q <= 16'd0;
      end else begin
         best_key_q    <= best_key_d;
         best_idx_q    <= best_idx_d;
         found_q       <= found_d;
         entry_cnt_q   <= entry_cnt_d;
         sweep_count_q <= sweep_count_d;
      end
   end

endmodule

// File: tb/tb_best_match_tracker.sv
// Scoreboard bench for best_match_tracker: driver pushes expected records, monitor pops on writes.
`timescale 1ns/1ps
module tb_best_match_tracker;

   localparam int N = 128;

   logic        bus_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        score_tvalid = 1'b0;
   logic        score_tready;
   logic [31:0] score_tdata = 32'd0;
   logic        score_tlast = 1'b0;
   logic        fifo_full = 1'b0;
   logic        fifo_wren;
   logic [31:0] fifo_din;
   logic        sweep_done;
   logic [15:0] sweep_count;

   best_match_tracker #(.NUM_ENTRIES(N), .IDX_W(16)) dut (
      .bus_clk      (bus_clk),
      .rst_n        (rst_n),
      .score_tvalid (score_tvalid),
      .score_tready (score_tready),
      .score_tdata  (score_tdata),
      .score_tlast  (score_tlast),
      .fifo_full    (fifo_full),
      .fifo_wren    (fifo_wren),
      .fifo_din     (fifo_din),
      .sweep_done   (sweep_done),
      .sweep_count  (sweep_count)
   );

   always #5 bus_clk = ~bus_clk;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] exp_q[$];
   int          recs = 0;
   bit          word_par = 1'b0;
   bit          pend_cnt = 1'b0;
   bit          rand_full = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Reference ordering on sign/magnitude: positives beat negatives (+0 beats -0),
   // larger magnitude wins among positives, smaller magnitude wins among negatives
   function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   function automatic bit isnan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   // Exact fp32 bits of a small positive integer
   function automatic logic [31:0] f2b(input int n);
      int e = 0;
      logic [31:0] m;
      while ((n >> (e + 1)) != 0) e++;
      m = 32'(n);
      m = m << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   function automatic logic [31:0] rval(input logic [31:0] prev);
      case ($urandom_range(0, 9))
         0: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         1: return 32'h7F800000;
         2: return 32'hFF800000;
         3: return 32'h00000000;
         4: return 32'h80000000;
         5: return prev;
         default: return $urandom;
      endcase
   endfunction

   task automatic push_rec(input logic [31:0] w0, input logic [31:0] w1);
      exp_q.push_back(w0);
      exp_q.push_back(w1);
   endtask

   task automatic push_model(input logic [31:0] v[$]);
      int bi = -1;
      foreach (v[i])
         if (!isnan(v[i]) && (bi < 0 || fgt(v[i], v[bi]))) bi = i;
      if (bi < 0) push_rec(32'h00000000, 32'hFF800000);
      else        push_rec(32'h80000000 | 32'(bi), v[bi]);
   endtask

   // Present one score and return just after the edge where it was accepted
   task automatic send_score(input logic [31:0] v, input bit last, input int gap_pct);
      int budget = 0;
      while ($urandom_range(0, 99) < gap_pct) begin
         score_tvalid = 1'b0;
         @(posedge bus_clk); #1;
      end
      score_tvalid = 1'b1;
      score_tdata  = v;
      score_tlast  = last;
      forever begin
         @(negedge bus_clk);
         if (score_tready) begin
            @(posedge bus_clk); #1;
            break;
         end
         budget++;
         if (budget > 1000) begin
            checks++;
            $display("FAIL accept_timeout: tready stayed 0 for %0d cycles, required 1", budget);
            break;
         end
      end
      score_tlast = 1'b0;
   endtask

   task automatic send_sweep(input logic [31:0] v[$], input bit tlast_end, input int gap_pct);
      foreach (v[i]) send_score(v[i], tlast_end && (i == v.size() - 1), gap_pct);
   endtask

   task automatic idle(input int n);
      score_tvalid = 1'b0;
      repeat (n) @(posedge bus_clk);
      #1;
   endtask

   task automatic drain();
      int b = 0;
      while ((exp_q.size() != 0 || word_par) && b < 2000) begin
         @(posedge bus_clk);
         b++;
      end
      if (b >= 2000) begin
         checks++;
         $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
      end
      repeat (2) @(posedge bus_clk);
      #1;
   endtask

   // Monitor: every FIFO write is popped against the scoreboard
   always @(negedge bus_clk) begin
      if (rst_n) begin
         if (pend_cnt) begin
            chk("sweep_count", 32'(sweep_count), recs & 32'hFFFF);
            pend_cnt = 1'b0;
         end
         if (fifo_full) chk("wren_while_full", 32'(fifo_wren), 32'd0);
         if (fifo_wren) begin
            chk("tready_during_emit", 32'(score_tready), 32'd0);
            chk("sweep_done", 32'(sweep_done), 32'(word_par));
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: got 0x%08h, required no write", fifo_din);
            end else begin
               chk("fifo_din", fifo_din, exp_q.pop_front());
            end
            if (word_par) begin
               recs++;
               pend_cnt = 1'b1;
            end
            word_par = ~word_par;
         end else if (sweep_done) begin
            chk("sweep_done_without_write", 32'(sweep_done), 32'd0);
         end
      end
   end

   // Random back-pressure from the host FIFO
   always @(posedge bus_clk) begin
      if (rand_full) begin
         #1;
         fifo_full = ($urandom_range(0, 3) == 0);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v[$];
      logic [31:0] prev;
      int          len;

      // Reset values
      repeat (3) @(posedge bus_clk);
      @(negedge bus_clk);
      chk("rst_tready", 32'(score_tready), 32'd0);
      chk("rst_wren", 32'(fifo_wren), 32'd0);
      chk("rst_din", fifo_din, 32'd0);
      chk("rst_sweep_done", 32'(sweep_done), 32'd0);
      chk("rst_sweep_count", 32'(sweep_count), 32'd0);
      @(posedge bus_clk); #1;
      rst_n = 1'b1;
      idle(2);

      // 1: ascending 1.0..128.0, closed by count
      v.delete();
      for (int i = 1; i <= N; i++) v.push_back(f2b(i));
      send_sweep(v, 1'b0, 0);
      push_rec(32'h8000007F, 32'h43000000);
      idle(1);
      drain();
      chk("t1_sweep_count", 32'(sweep_count), 32'd1);

      // 2: tie keeps the earlier index
      v = '{32'h3F000000, 32'h3F666666, 32'h3F666666, 32'hC0000000};
      send_sweep(v, 1'b1, 0);
      push_rec(32'h80000001, 32'h3F666666);
      idle(1);
      drain();

      // 3: all-NaN sweep reports not-found and -inf
      v = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
      send_sweep(v, 1'b1, 0);
      push_rec(32'h00000000, 32'hFF800000);
      idle(1);
      drain();

      // 4: -0 vs +0 with the FIFO full across the idx word; tvalid stays high
      fifo_full = 1'b1;
      v = '{32'h80000000, 32'h00000000};
      send_sweep(v, 1'b1, 0);
      push_rec(32'h80000001, 32'h00000000);
      score_tdata = 32'h7F7FFFFF;
      repeat (5) begin
         @(negedge bus_clk);
         chk("stall_tready", 32'(score_tready), 32'd0);
         chk("stall_wren", 32'(fifo_wren), 32'd0);
      end
      @(posedge bus_clk); #1;
      fifo_full = 1'b0;
      idle(1);
      drain();

      // 5: reset mid-sweep drops the partial record
      v.delete();
      prev = 32'h3F800000;
      for (int i = 0; i < 40; i++) begin
         prev = rval(prev);
         v.push_back(prev);
      end
      send_sweep(v, 1'b0, 20);
      score_tvalid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      word_par = 1'b0;
      pend_cnt = 1'b0;
      recs = 0;
      repeat (2) @(posedge bus_clk);
      @(negedge bus_clk);
      chk("midrst_tready", 32'(score_tready), 32'd0);
      chk("midrst_wren", 32'(fifo_wren), 32'd0);
      chk("midrst_sweep_count", 32'(sweep_count), 32'd0);
      @(posedge bus_clk); #1;
      rst_n = 1'b1;
      idle(6);
      v.delete();
      for (int i = 0; i < N; i++) begin
         prev = rval(prev);
         v.push_back(prev);
      end
      send_sweep(v, 1'b0, 10);
      push_model(v);
      idle(1);
      drain();

      // 6: three back-to-back sweeps with tvalid held high
      for (int s = 0; s < 3; s++) begin
         len = (s == 1) ? N : $urandom_range(1, 40);
         v.delete();
         for (int i = 0; i < len; i++) begin
            prev = rval(prev);
            v.push_back(prev);
         end
         send_sweep(v, len < N, 0);
         push_model(v);
      end
      idle(1);
      drain();
      chk("t6_sweep_count", 32'(sweep_count), 32'd4);

      // 7: random sweeps with gaps and random back-pressure
      rand_full = 1'b1;
      for (int s = 0; s < 20; s++) begin
         len = ($urandom_range(0, 4) == 0) ? N : $urandom_range(1, N);
         v.delete();
         for (int i = 0; i < len; i++) begin
            prev = rval(prev);
            v.push_back(prev);
         end
         send_sweep(v, (len < N) || $urandom_range(0, 1) == 1, 30);
         push_model(v);
      end
      score_tvalid = 1'b0;
      @(posedge bus_clk);
      rand_full = 1'b0;
      #2;
      fifo_full = 1'b0;
      drain();
      chk("final_sweep_count", 32'(sweep_count), recs & 32'hFFFF);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
